// File: rtl/vram_cpu_port.sv
// vram_cpu_port: Z80 access port for the 1 KiB tile RAM window.
// Optional feature macro: VRAM_TIMEOUT_EN. When defined, a WAIT_FREE
// period longer than TIMEOUT_CYCLES forces a release (reads return 8'hFF,
// writes are dropped) and sets the sticky timeout_flag.
// Handshake: a request is live while mreq is low, the address hits the
// window and exactly one CPU strobe is low. The CPU is held on WAIT for
// every live-request cycle until DONE. A RAM strobe is only asserted in a
// cycle where vram_busy=0, so each committed access issues exactly one
// write strobe cycle (or one read strobe pair: address + capture).
module vram_cpu_port #(
  parameter logic [15:0] BASE_ADDR      = 16'h7400,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_dout_en,
  output logic        cpu_wait_n,
  input  logic        vram_busy,
  output logic        tile_ena,
  output logic        vram_rdn,
  output logic        vram_wrn,
  output logic [9:0]  vram_addr,
  output logic [7:0]  vram_din,
  input  logic [7:0]  vram_dout,
  output logic        timeout_flag,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FREE = 3'd1,
    S_ACCESS    = 3'd2,
    S_CAPTURE   = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_hit;
  logic        w_req;
  logic        w_release;
  logic        w_take_data;
  logic        w_timeout;
  logic        w_to_fire;
  logic        w_in_access;
  logic        r_is_rd;
  logic [9:0]  r_addr;
  logic [7:0]  r_din;
  logic [7:0]  r_dout;

  // Request decode; reset masks the request so WAIT is released during reset.
  assign w_hit     = (cpu_addr[15:10] == BASE_ADDR[15:10]);
  assign w_req     = !rst && !cpu_mreq_n && w_hit && (cpu_rd_n ^ cpu_wr_n);
  assign w_release = cpu_mreq_n || (cpu_rd_n && cpu_wr_n);
  assign w_to_fire = (r_state == S_WAIT_FREE) && vram_busy && w_timeout;

`ifdef VRAM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_flag;

  assign w_timeout    = (r_cnt == CNT_LAST);
  assign timeout_flag = r_timeout_flag;

  // Count consecutive WAIT_FREE cycles; cleared whenever WAIT_FREE is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT_FREE && w_next == S_WAIT_FREE) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Sticky timeout indicator, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout_flag <= 1'b0;
    end else if (w_to_fire) begin
      r_timeout_flag <= 1'b1;
    end
  end
`else
  // No counter in this build: WAIT_FREE waits for as long as the RAM is busy.
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign timeout_flag     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a busy RAM during ACCESS/CAPTURE forces a retry.
  always_comb begin
    w_next      = r_state;
    w_take_data = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) w_next = S_WAIT_FREE;
      end
      S_WAIT_FREE: begin
        if (!vram_busy)     w_next = S_ACCESS;
        else if (w_to_fire) w_next = S_DONE;
      end
      S_ACCESS: begin
        if (vram_busy)    w_next = S_WAIT_FREE;
        else if (r_is_rd) w_next = S_CAPTURE;
        else              w_next = S_DONE;
      end
      S_CAPTURE: begin
        if (vram_busy) begin
          w_next = S_WAIT_FREE;
        end else begin
          w_next      = S_DONE;
          w_take_data = 1'b1;
        end
      end
      S_DONE: begin
        if (w_release) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch offset, write data and direction when a request is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_din   <= '0;
      r_is_rd <= 1'b0;
    end else if (r_state == S_IDLE && w_req) begin
      r_addr  <= cpu_addr[9:0];
      r_din   <= cpu_din;
      r_is_rd <= !cpu_rd_n;
    end
  end

  // Read data register: RAM data on capture, 8'hFF on a forced release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
    end else if (w_take_data) begin
      r_dout <= vram_dout;
    end else if (w_to_fire && r_is_rd) begin
      r_dout <= 8'hFF;
    end
  end

  // RAM-side strobes are gated by vram_busy so a retried cycle issues nothing.
  assign w_in_access = (r_state == S_ACCESS) || (r_state == S_CAPTURE);
  assign tile_ena    = w_in_access;
  assign vram_wrn    = !((r_state == S_ACCESS) && !r_is_rd && !vram_busy);
  assign vram_rdn    = !(w_in_access && r_is_rd && !vram_busy);
  assign vram_addr   = r_addr;
  assign vram_din    = r_din;

  // CPU-side outputs.
  assign cpu_wait_n  = !(w_req && (r_state != S_DONE));
  assign cpu_dout    = r_dout;
  assign cpu_dout_en = (r_state == S_DONE) && r_is_rd;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_vram_cpu_port.sv
// tb_vram_cpu_port: scoreboard bench for vram_cpu_port with a small
// synchronous tile RAM model (read data valid one clock after the strobe).
module tb_vram_cpu_port;

  localparam int LIMIT = 2000;
`ifdef VRAM_TIMEOUT_EN
  localparam logic EXP_TO_FLAG = 1'b1;
`else
  localparam logic EXP_TO_FLAG = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_dout_en, cpu_wait_n;
  logic        vram_busy, tile_ena, vram_rdn, vram_wrn;
  logic [9:0]  vram_addr;
  logic [7:0]  vram_din, vram_dout;
  logic        timeout_flag;
  logic [2:0]  dbg_state;

  vram_cpu_port dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_mreq_n   (cpu_mreq_n),
    .cpu_rd_n     (cpu_rd_n),
    .cpu_wr_n     (cpu_wr_n),
    .cpu_addr     (cpu_addr),
    .cpu_din      (cpu_din),
    .cpu_dout     (cpu_dout),
    .cpu_dout_en  (cpu_dout_en),
    .cpu_wait_n   (cpu_wait_n),
    .vram_busy    (vram_busy),
    .tile_ena     (tile_ena),
    .vram_rdn     (vram_rdn),
    .vram_wrn     (vram_wrn),
    .vram_addr    (vram_addr),
    .vram_din     (vram_din),
    .vram_dout    (vram_dout),
    .timeout_flag (timeout_flag),
    .dbg_state    (dbg_state)
  );

  // ---------------- tile RAM model ----------------
  logic [7:0] ram    [1024];
  logic [7:0] shadow [1024];
  logic       ram_load;

  function automatic logic [7:0] init_val(input int i);
    if (i == 'h3BF) return 8'h3C;
    return 8'(i * 37 + (i >> 3) + 5);
  endfunction

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
    end else begin
      if (tile_ena && !vram_wrn) ram[vram_addr] <= vram_din;
      if (tile_ena && !vram_rdn) vram_dout <= ram[vram_addr];
    end
  end

  // ---------------- scoreboard ----------------
  logic [17:0] exp_wr_q[$];
  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  last_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  logic        prev_en;
  logic [17:0] e_wr;
  logic [7:0]  e_rd;

  // Pop expected write on every RAM write strobe, expected read data on DONE entry.
  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (tile_ena && !vram_wrn) begin
        check("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0) begin
          e_wr = exp_wr_q.pop_front();
          check("wr_addr_data", 32'({vram_addr, vram_din}), 32'(e_wr));
        end
      end
      if (cpu_dout_en && !prev_en) begin
        check("rd_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e_rd = exp_q.pop_front();
          check("rd_data", 32'(cpu_dout), 32'(e_rd));
        end
      end
      prev_en = cpu_dout_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    cpu_mreq_n = 1'b1;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wait_n"},  32'(cpu_wait_n),   32'd1);
    check({tag, "_dout_en"}, 32'(cpu_dout_en),  32'd0);
    check({tag, "_dout"},    32'(cpu_dout),     32'd0);
    check({tag, "_tile_ena"},32'(tile_ena),     32'd0);
    check({tag, "_rdn"},     32'(vram_rdn),     32'd1);
    check({tag, "_wrn"},     32'(vram_wrn),     32'd1);
    check({tag, "_addr"},    32'(vram_addr),    32'd0);
    check({tag, "_din"},     32'(vram_din),     32'd0);
    check({tag, "_to_flag"}, 32'(timeout_flag), 32'd0);
    check({tag, "_state"},   32'(dbg_state),    32'd0);
  endtask

  // One CPU access starting at posedge+1 (cycle c0). busy_pat[k] drives
  // vram_busy in cycle ck (busy_tail after bit 63). The CPU address/data
  // are scrambled from c1 on to show they are latched. Ends at posedge+1.
  task automatic cpu_access(input logic is_rd, input logic [15:0] addr, input logic [7:0] wdata,
                            input logic [63:0] busy_pat, input logic busy_tail,
                            input int exp_lat, input int wf_cycle, input logic expect_to,
                            input string tag);
    int lat;
    int wr_cnt;
    logic [7:0] exp_d;
    lat    = -1;
    wr_cnt = 0;
    exp_d  = last_dout;
    if (is_rd) begin
      exp_d = expect_to ? 8'hFF : shadow[addr[9:0]];
      exp_q.push_back(exp_d);
    end else if (!expect_to) begin
      exp_wr_q.push_back({addr[9:0], wdata});
      shadow[addr[9:0]] = wdata;
    end
    cpu_addr   = addr;
    cpu_din    = wdata;
    cpu_mreq_n = 1'b0;
    cpu_rd_n   = !is_rd;
    cpu_wr_n   = is_rd;
    for (int k = 0; k < LIMIT; k++) begin
      vram_busy = (k < 64) ? busy_pat[k] : busy_tail;
      if (k == 1) begin
        cpu_addr = {addr[15:10], ~addr[9:0]};
        cpu_din  = ~wdata;
      end
      @(negedge clk);
      if (tile_ena && !vram_wrn) wr_cnt++;
      if (k == wf_cycle) check({tag, "_retry_state"}, 32'(dbg_state), 32'd1);
      if (cpu_wait_n) begin
        lat = k;
        break;
      end
      check({tag, "_dout_hold"}, 32'(cpu_dout), 32'(last_dout));
      @(posedge clk);
      #1;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_dout_en"}, 32'(cpu_dout_en), 32'(is_rd));
    check({tag, "_wr_strobes"}, 32'(wr_cnt), 32'((!is_rd && !expect_to) ? 1 : 0));
    last_dout = exp_d;
    @(posedge clk);
    #1;
    bus_idle();
    vram_busy = 1'b0;
    @(negedge clk);
    check({tag, "_wait_after"}, 32'(cpu_wait_n), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_back_idle"}, 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        r_is_rd;
    logic [9:0]  r_off;
    int          nb;
    logic [63:0] pat;

    rst       = 1'b1;
    ram_load  = 1'b1;
    vram_busy = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_din   = 8'h00;
    last_dout = 8'h00;
    bus_idle();
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    @(negedge clk);
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    ram_load = 1'b0;
    @(posedge clk);
    #1;

    // Uncontended write: strobe at c2, release at c3.
    cpu_access(1'b0, 16'h7440, 8'hA5, 64'h0, 1'b0, 3, -1, 1'b0, "wr_basic");
    // Read with 20 busy WAIT_FREE cycles: DONE at c24.
    cpu_access(1'b1, 16'h77BF, 8'h00, 64'h1F_FFFE, 1'b0, 24, -1, 1'b0, "rd_busy20");
    // Read with busy during CAPTURE: back to WAIT_FREE at c4, DONE at c7.
    cpu_access(1'b1, 16'h7440, 8'h00, 64'h8, 1'b0, 7, 4, 1'b0, "rd_cap_retry");
    // Write with busy during ACCESS: one strobe only, DONE at c5.
    cpu_access(1'b0, 16'h7455, 8'h5A, 64'h4, 1'b0, 5, 3, 1'b0, "wr_acc_retry");
    cpu_access(1'b1, 16'h7455, 8'h00, 64'h0, 1'b0, 4, -1, 1'b0, "rd_back");

    // Misses and an illegal both-strobes cycle: nothing happens.
    for (int m = 0; m < 3; m++) begin
      cpu_mreq_n = 1'b0;
      cpu_din    = 8'hEE;
      case (m)
        0: begin cpu_addr = 16'h7800; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1; end
        1: begin cpu_addr = 16'h73FF; cpu_rd_n = 1'b1; cpu_wr_n = 1'b0; end
        default: begin cpu_addr = 16'h7440; cpu_rd_n = 1'b0; cpu_wr_n = 1'b0; end
      endcase
      repeat (3) begin
        @(negedge clk);
        check($sformatf("miss%0d_tile_ena", m), 32'(tile_ena), 32'd0);
        check($sformatf("miss%0d_wait_n", m), 32'(cpu_wait_n), 32'd1);
        check($sformatf("miss%0d_state", m), 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
      end
      bus_idle();
      @(posedge clk);
      #1;
    end

    // Reset asserted while held in WAIT_FREE, request still on the bus.
    cpu_addr   = 16'h7440;
    cpu_din    = 8'hA5;
    cpu_mreq_n = 1'b0;
    cpu_wr_n   = 1'b0;
    vram_busy  = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_pre_state", 32'(dbg_state), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    last_dout = 8'h00;
    @(posedge clk);
    #1;
    bus_idle();
    vram_busy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cpu_access(1'b0, 16'h7440, 8'hA5, 64'h0, 1'b0, 3, -1, 1'b0, "wr_after_rst");

    // Random accesses with short busy bursts at c1..cnb.
    for (int n = 0; n < 8; n++) begin
      r_is_rd = 1'($urandom_range(0, 1));
      r_off   = 10'($urandom_range(0, 1023));
      nb      = $urandom_range(0, 4);
      pat     = ((64'd1 << (nb + 1)) - 64'd1) & ~64'd1;
      cpu_access(r_is_rd, {6'b011101, r_off}, 8'($urandom_range(0, 255)), pat, 1'b0,
                 (r_is_rd ? 4 : 3) + nb, -1, 1'b0, $sformatf("rand%0d", n));
    end

`ifdef VRAM_TIMEOUT_EN
    // RAM busy forever: forced release after 1024 WAIT_FREE cycles.
    cpu_access(1'b1, 16'h7523, 8'h00, '1, 1'b1, 1025, -1, 1'b1, "rd_timeout");
    check("to_flag_set", 32'(timeout_flag), 32'd1);
    cpu_access(1'b1, 16'h7440, 8'h00, 64'h0, 1'b0, 4, -1, 1'b0, "rd_after_to");
`endif

    check("to_flag_final", 32'(timeout_flag), 32'(EXP_TO_FLAG));
    check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
